// File: rtl/btn_conditioner.sv
// Purpose: six push-button conditioner; sync, debounce, press pulses, up/down auto-repeat.
// Latency: press pulse DB_CYCLES+2 cycles after the raw level is first sampled; repeats REP_DELAY then every REP_PERIOD.
// Backpressure: none; outputs are one-cycle strobes with no handshake, the consumer must take them as they come.
//
// Ports:
//   clk, rst_n                               - clock, asynchronous active-low reset
//   up, down, left, right, start, modify     - raw button levels, active-high, asynchronous
//   up_p .. modify_p                         - one-cycle command pulses
//   held[5:0]                                - debounced levels {modify,start,right,left,down,up}
module btn_conditioner #(
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned REP_DELAY  = 50_000_000,
  parameter int unsigned REP_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       modify,
  output logic       up_p,
  output logic       down_p,
  output logic       left_p,
  output logic       right_p,
  output logic       start_p,
  output logic       modify_p,
  output logic [5:0] held
);

  localparam int NCH = 6;
  localparam int CW  = 24;
  localparam int RW  = 32;

  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REPEAT
  } rep_state_e;

  // ---------------------------------------------------------------------------
  // Reset: asserts immediately, releases two edges after rst_n rises.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Input synchronizers. These sit on the raw reset so they start sampling on
  // the first edge after release; their output is valid exactly when the
  // internal reset lets the debouncers run, which keeps the post-reset press
  // latency at DB_CYCLES+3.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] raw;
  logic [NCH-1:0] meta_q, meta_d;
  logic [NCH-1:0] sync_q, sync_d;

  assign raw = {modify, start, right, left, down, up};

  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: level changes only after DB_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] db_q, db_d;
  logic [NCH-1:0] db_prev_q, db_prev_d;
  logic [NCH-1:0] rise;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  always_comb begin
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i]  = sync_q[i];
        else                     cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Rise seen one cycle after the debounced level changes, so the pulse lands
  // on the cycle after acceptance.
  assign rise = db_q & ~db_prev_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat for up (0) and down (1). Holding both is treated as a
  // conflicting request: both machines drop to IDLE and stay there until a
  // fresh press.
  // ---------------------------------------------------------------------------
  rep_state_e     st_q   [2];
  rep_state_e     st_d   [2];
  logic [RW-1:0]  rcnt_q [2];
  logic [RW-1:0]  rcnt_d [2];
  logic [1:0]     rep_fire;
  logic           both_held;

  assign both_held = db_q[0] & db_q[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]     = st_q[i];
      rcnt_d[i]   = rcnt_q[i];
      rep_fire[i] = 1'b0;
      if (both_held) begin
        st_d[i]   = IDLE;
        rcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          IDLE: begin
            if (rise[i]) begin
              st_d[i]   = WAIT;
              rcnt_d[i] = '0;
            end
          end
          WAIT: begin
            if (!db_q[i]) begin
              st_d[i]   = IDLE;
              rcnt_d[i] = '0;
            end else if (rcnt_q[i] == DELAY_LAST) begin
              rep_fire[i] = 1'b1;
              rcnt_d[i]   = '0;
              st_d[i]     = REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          REPEAT: begin
            if (!db_q[i]) begin
              st_d[i]   = IDLE;
              rcnt_d[i] = '0;
            end else if (rcnt_q[i] == PERIOD_LAST) begin
              rep_fire[i] = 1'b1;
              rcnt_d[i]   = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= IDLE;
        rcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output pulses. Press and repeat merge into one strobe; masking with the
  // previous cycle guarantees a pulse never stretches to two cycles even with
  // degenerate repeat settings.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] p_q, p_d;

  always_comb p_d = (rise | {{(NCH-2){1'b0}}, rep_fire}) & ~p_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) p_q <= '0;
    else            p_q <= p_d;
  end

  assign up_p     = p_q[0];
  assign down_p   = p_q[1];
  assign left_p   = p_q[2];
  assign right_p  = p_q[3];
  assign start_p  = p_q[4];
  assign modify_p = p_q[5];
  assign held     = db_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] braw;
  logic       up_p, down_p, left_p, right_p, start_p, modify_p;
  logic [5:0] held;
  logic [5:0] dut_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up      (braw[0]),
    .down    (braw[1]),
    .left    (braw[2]),
    .right   (braw[3]),
    .start   (braw[4]),
    .modify  (braw[5]),
    .up_p    (up_p),
    .down_p  (down_p),
    .left_p  (left_p),
    .right_p (right_p),
    .start_p (start_p),
    .modify_p(modify_p),
    .held    (held)
  );

  assign dut_p = {modify_p, start_p, right_p, left_p, down_p, up_p};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: debounced level flips once the last DB synchronized
  // samples all disagree with it; repeats are timed by elapsed cycles since
  // the press pulse.
  // ---------------------------------------------------------------------------
  logic       model_en = 1'b0;
  logic [5:0] m_meta, m_d, m_dprev, m_p;
  logic [5:0] m_sh [DB];
  int         m_arm [2];
  int         m_n;

  task automatic model_init();
    m_meta  = '0;
    m_d     = '0;
    m_dprev = '0;
    m_p     = '0;
    for (int k = 0; k < DB; k++) m_sh[k] = '0;
    m_arm[0] = -1;
    m_arm[1] = -1;
    m_n = 0;
  endtask

  always @(posedge clk) begin
    if (model_en) begin : mdl
      logic [5:0] diff, d_new, press, rep;
      int el;
      m_n = m_n + 1;
      diff = 6'h3f;
      for (int k = 0; k < DB; k++) diff = diff & (m_sh[k] ^ m_d);
      d_new = m_d ^ diff;
      press = m_d & ~m_dprev;
      rep   = '0;
      for (int i = 0; i < 2; i++) begin
        if (!m_d[i] || (m_d[0] && m_d[1])) m_arm[i] = -1;
        else if (m_arm[i] >= 0) begin
          el = m_n - m_arm[i];
          if (el == RD || (el > RD && ((el - RD) % RP) == 0)) rep[i] = 1'b1;
        end
        if (press[i] && !(m_d[0] && m_d[1])) m_arm[i] = m_n;
      end
      for (int k = DB - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = m_meta;
      m_meta  = braw;
      m_dprev = m_d;
      m_d     = d_new;
      m_p     = (press | rep) & ~m_p;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table: one button pattern held for 'hold' cycles from a quiet state.
  // cnt is one hex digit per channel {modify,start,right,left,down,up}.
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [5:0]  raw;
    int          hold;
    logic [23:0] cnt;
    int          first;
    logic [5:0]  held6;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  function automatic vec_t mk(input string n, input logic [5:0] r, input int h,
                              input logic [23:0] cn, input int f, input logic [5:0] hd);
    vec_t v;
    v.name = n; v.raw = r; v.hold = h; v.cnt = cn; v.first = f; v.held6 = hd;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk("start_20",  6'b010000, 20, 24'h010000,  6, 6'b010000);
    tbl[1] = mk("left_3",    6'b000100,  3, 24'h000000, -1, 6'b000000);
    tbl[2] = mk("left_4",    6'b000100,  4, 24'h000100,  6, 6'b000100);
    tbl[3] = mk("mod_right", 6'b101000,  8, 24'h101000,  6, 6'b101000);
    tbl[4] = mk("down_10",   6'b000010, 10, 24'h000010,  6, 6'b000010);
    tbl[5] = mk("down_11",   6'b000010, 11, 24'h000020,  6, 6'b000010);
    tbl[6] = mk("all_six",   6'b111111, 20, 24'h111111,  6, 6'b111111);

    braw  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_async", 32'({held, dut_p}), 32'h0);
    repeat (3) @(negedge clk);
    check("reset_hold", 32'({held, dut_p}), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_after_reset", 32'({held, dut_p}), 32'h0);

    // Table-driven single patterns.
    for (int v = 0; v < NV; v++) begin
      int cnt [6];
      int first;
      logic [5:0] prev;
      first = -1;
      prev  = '0;
      for (int ch = 0; ch < 6; ch++) cnt[ch] = 0;
      braw = tbl[v].raw;
      for (int c = 0; c < tbl[v].hold + 30; c++) begin
        @(negedge clk);
        for (int ch = 0; ch < 6; ch++) if (dut_p[ch]) cnt[ch]++;
        if (dut_p != '0 && first < 0) first = c;
        check({tbl[v].name, "_single_cycle"}, 32'(dut_p & prev), 32'h0);
        prev = dut_p;
        if (c == 4) check({tbl[v].name, "_held_early"}, 32'(held), 32'h0);
        if (c == 5) check({tbl[v].name, "_held"}, 32'(held), 32'(tbl[v].held6));
        if (c == tbl[v].hold - 1) braw = '0;
      end
      for (int ch = 0; ch < 6; ch++)
        check({tbl[v].name, "_count"}, 32'(cnt[ch]), 32'(tbl[v].cnt[ch*4 +: 4]));
      check({tbl[v].name, "_first"}, 32'(first), 32'(tbl[v].first));
      check({tbl[v].name, "_held_end"}, 32'(held), 32'h0);
    end

    // up held: press, first repeat after REP_DELAY, then every REP_PERIOD;
    // the repeat due on the cycle the release is accepted must not appear.
    begin
      int pts [$];
      int others;
      int exp_up [6];
      exp_up = '{6, 16, 19, 22, 25, 28};
      others = 0;
      braw = 6'b000001;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (up_p) pts.push_back(c);
        if ((dut_p & 6'b111110) != '0) others++;
        if (c == 24) braw = '0;
      end
      check("up_rep_count", 32'(pts.size()), 32'd6);
      for (int i = 0; i < 6; i++)
        if (i < pts.size()) check("up_rep_time", 32'(pts[i]), 32'(exp_up[i]));
      check("up_rep_others", 32'(others), 32'd0);
    end

    // left glitch train 3 high, 1 low, 3 high: never accepted.
    begin
      logic [6:0] pat;
      int lp;
      logic seen;
      pat  = 7'b1110111;
      lp   = 0;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
        braw[2] = (c < 7) ? pat[6-c] : 1'b0;
        @(negedge clk);
        if (left_p) lp++;
        seen = seen | held[2];
      end
      check("left_glitch_pulses", 32'(lp), 32'd0);
      check("left_glitch_held", 32'(seen), 32'd0);
    end

    // up then down two cycles later: presses only, repeats suppressed.
    begin
      int upc, dnc;
      upc = 0;
      dnc = 0;
      for (int c = 0; c < 70; c++) begin
        braw[0] = (c < 30);
        braw[1] = (c >= 2 && c < 32);
        @(negedge clk);
        if (up_p)   upc++;
        if (down_p) dnc++;
      end
      check("updown_up_pulses", 32'(upc), 32'd1);
      check("updown_down_pulses", 32'(dnc), 32'd1);
    end

    // Reset while repeating with up still held.
    begin
      braw = 6'b000001;
      repeat (20) @(negedge clk);
      check("rst_pre_held", 32'(held[0]), 32'd1);
      rst_n = 1'b0;
      #1 check("rst_mid_outputs", 32'({held, dut_p}), 32'h0);
      @(negedge clk);
      check("rst_mid_low", 32'({held, dut_p}), 32'h0);
      rst_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
        @(negedge clk);
        check("rst_release_up_p", 32'(dut_p), (e == 7) ? 32'h1 : 32'h0);
        if (e == 5) check("rst_release_held5", 32'(held[0]), 32'd0);
        if (e == 6) check("rst_release_held6", 32'(held[0]), 32'd1);
      end
      braw = '0;
      repeat (30) @(negedge clk);
      check("rst_seq_quiet", 32'({held, dut_p}), 32'h0);
    end

    // Randomized level changes against the reference model.
    begin
      int hold_left [6];
      model_init();
      for (int ch = 0; ch < 6; ch++) hold_left[ch] = $urandom_range(1, 30);
      model_en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        for (int ch = 0; ch < 6; ch++) begin
          if (hold_left[ch] == 0) begin
            braw[ch] = ~braw[ch];
            hold_left[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                        : $urandom_range(5, 40);
          end else begin
            hold_left[ch]--;
          end
        end
        @(negedge clk);
        check("random_vs_model", 32'({held, dut_p}), 32'({m_d, m_p}));
      end
      model_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
